interrupt_arbiter: RTL and testbench
====================================

// Module: interrupt_arbiter
// PURPOSE
//  Front end of the interrupt path, directly upstream of the interrupt-started flag.
//  Synchronises the external irq_n/nmi_n pins and latches NMI falling edges.
//  Prioritises reset, NMI, IRQ and BRK at instruction boundaries.
//  Drives int_start (the flag's set input) and int_done (its reset input).
//  Holds the winning source's vector address for the vector-fetch microcode.
// PARAMETERS
//  SYNC_STAGES  2        flops in each pin synchroniser (>=2)
//  NMI_VECTOR   16'hFFFA NMI vector low-byte address
//  RST_VECTOR   16'hFFFC reset vector low-byte address
//  IRQ_VECTOR   16'hFFFE IRQ/BRK vector low-byte address
// PORTS
//  clk        in  1  system clock
//  nrst       in  1  reset, asynchronous, active-low
//  enableFFs  in  1  CPU phase enable; FSM and latched outputs advance only when high
//  irq_n      in  1  async IRQ pin, level-sensitive, active-low
//  nmi_n      in  1  async NMI pin, falling-edge-sensitive
//  i_flag     in  1  status register I (IRQ mask)
//  poll       in  1  instruction boundary: the decoder is about to fetch an opcode
//  brk_inst   in  1  the current opcode is BRK (valid together with poll)
//  vec_done   in  1  microcode finished fetching the vector high byte
//  int_start  out 1  combinational: service begins on this enabled edge
//  int_done   out 1  combinational: service ends on this enabled edge (= SERVICE & vec_done)
//  int_src    out 3  int_src_t of the source in service (SRC_NONE when idle)
//  vector     out 16 vector low-byte address for int_src (0 when idle)
//  b_push     out 1  B bit to push with P: 1 only for BRK
//  nmi_pend   out 1  NMI edge latched but not yet serviced
// BEHAVIOUR
//  Reset values
//   - FSM state RST_PEND; nmi_latch=0; synchroniser flops=1 (pins idle high).
//   - int_src=SRC_NONE; vector=0; b_push=0.
//  Synchronisers and the NMI edge detector run on every clk, not gated by enableFFs, so no edge is lost.
//  NMI edge detector
//   - Falling edge = synchronised prev 1 -> now 0; sets nmi_latch.
//   - Latency: pin edge to nmi_pend is SYNC_STAGES+1 clk.
//   - Holding nmi_n low produces no further edges.
//   - nmi_latch clears only on an enabled edge where int_start && winner==SRC_NMI.
//   - A new edge arriving on that same clk wins: set has priority over clear.
//  IRQ is level-sensitive: irq_req = ~irq_sync & ~i_flag. It is not latched.
//  Winner at a poll, in priority order:
//   RST_PEND > nmi_latch > irq_req > brk_inst > none.
//  FSM states: RST_PEND, IDLE, SERVICE. It advances only on posedge clk with enableFFs=1.
//   RST_PEND: int_start = poll. Takes SRC_RESET and goes to SERVICE.
//   IDLE: int_start = poll & (winner != none). Goes to SERVICE and latches int_src, vector and b_push.
//   SERVICE: int_start=0, so there is no nesting. vec_done -> IDLE and clears int_src, vector and b_push.
//  Vector lock
//   - int_src and vector are locked at int_start and stay fixed for the whole service.
//   - No NMI hijack: an NMI arriving during IRQ/BRK service stays pending.
//   - It is taken at the first poll after return to IDLE.
//  Other rules
//   - poll and vec_done on the same enabled edge: vec_done acts; poll is ignored (decoder never does this).
//   - enableFFs=0: FSM and all outputs hold; int_start/int_done forced 0.
//   - nrst assertion mid-service: immediate async return to RST_PEND; any pending NMI is discarded.
//  Vector mapping
//   - SRC_RESET uses RST_VECTOR; SRC_NMI uses NMI_VECTOR.
//   - SRC_IRQ and SRC_BRK both use IRQ_VECTOR; b_push=1 only for SRC_BRK.
// STRUCTURE
//  Package interrupt_pkg
//   - typedef enum logic[2:0] int_src_t {SRC_NONE, SRC_RESET, SRC_NMI, SRC_IRQ, SRC_BRK}.
//   - typedef enum arb_state_t {RST_PEND, IDLE, SERVICE}.
//   - Default vector localparams.
//  Sub-module pin_synchronizer #(SYNC_STAGES, RESET_VAL=1'b1)
//   - Instantiated twice, once for irq_n and once for nmi_n.
//  Edge detector, priority logic and FSM live in this module.
// TESTING
//  1. nrst release, then poll=1 with enableFFs=1 -> int_start=1, int_src=SRC_RESET, vector=16'hFFFC, b_push=0.
//     Then vec_done=1 -> int_done=1, back to IDLE, vector=0.
//  2. IDLE, i_flag=1, irq_n=0, poll -> int_start=0. Same with i_flag=0 -> int_src=SRC_IRQ, vector=16'hFFFE.
//  3. nmi_n pulsed low for 1 clk -> nmi_pend=1 after 3 clk; it holds until the next poll, which gives SRC_NMI/16'hFFFA.
//     nmi_n held low afterwards -> no second NMI.
//  4. irq_n=0, i_flag=0, NMI latched and brk_inst=1 at one poll -> SRC_NMI wins.
//     The following polls give SRC_IRQ, then BRK (after irq_n released) with b_push=1.
//  5. NMI edge during IRQ service -> vector stays 16'hFFFE, nmi_pend=1; NMI is taken at the first poll after vec_done.
//  6. enableFFs=0 while poll=1 -> no state change, int_start=0.
//     nrst pulsed mid-SERVICE -> RST_PEND, int_src=SRC_NONE, nmi_pend=0.

Source files
------------

// File: rtl/interrupt_pkg.sv
// ---------------------------------------------------------------------------
// interrupt_pkg : source/state encodings and default vectors for the arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package interrupt_pkg;

    typedef enum logic [2:0] {
        SRC_NONE  = 3'd0,
        SRC_RESET = 3'd1,
        SRC_NMI   = 3'd2,
        SRC_IRQ   = 3'd3,
        SRC_BRK   = 3'd4
    } int_src_t;

    typedef enum logic [1:0] {
        RST_PEND = 2'd0,
        IDLE     = 2'd1,
        SERVICE  = 2'd2
    } arb_state_t;

    localparam logic [15:0] DEF_NMI_VECTOR = 16'hFFFA;
    localparam logic [15:0] DEF_RST_VECTOR = 16'hFFFC;
    localparam logic [15:0] DEF_IRQ_VECTOR = 16'hFFFE;

endpackage

`default_nettype wire

// File: rtl/pin_synchronizer.sv
// ---------------------------------------------------------------------------
// pin_synchronizer : multi-flop synchroniser for an asynchronous input pin
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pin_synchronizer #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b1
) (
    input  logic clk,
    input  logic nrst,
    input  logic i_pin,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/interrupt_arbiter.sv
// ---------------------------------------------------------------------------
// interrupt_arbiter : pin sync, NMI edge latch, priority and service FSM
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module interrupt_arbiter
    import interrupt_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] NMI_VECTOR  = DEF_NMI_VECTOR,
    parameter logic [15:0] RST_VECTOR  = DEF_RST_VECTOR,
    parameter logic [15:0] IRQ_VECTOR  = DEF_IRQ_VECTOR
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        enableFFs,
    input  logic        irq_n,
    input  logic        nmi_n,
    input  logic        i_flag,
    input  logic        poll,
    input  logic        brk_inst,
    input  logic        vec_done,
    output logic        int_start,
    output logic        int_done,
    output int_src_t    int_src,
    output logic [15:0] vector,
    output logic        b_push,
    output logic        nmi_pend
);

    logic        w_irq_sync;
    logic        w_nmi_sync;
    logic        w_nmi_fall;
    logic        w_irq_req;
    logic        w_start;
    logic [15:0] w_vec;
    int_src_t    w_winner;

    logic        r_nmi_prev;
    logic        r_nmi_latch;
    arb_state_t  r_state;
    int_src_t    r_int_src;
    logic [15:0] r_vector;
    logic        r_b_push;

    pin_synchronizer #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_irq_sync (
        .clk    (clk),
        .nrst   (nrst),
        .i_pin  (irq_n),
        .o_sync (w_irq_sync)
    );

    pin_synchronizer #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_nmi_sync (
        .clk    (clk),
        .nrst   (nrst),
        .i_pin  (nmi_n),
        .o_sync (w_nmi_sync)
    );

    assign w_nmi_fall = r_nmi_prev & ~w_nmi_sync;
    assign w_irq_req  = ~w_irq_sync & ~i_flag;

    always_comb begin
        w_winner = SRC_NONE;
        if (r_state == RST_PEND)  w_winner = SRC_RESET;
        else if (r_nmi_latch)     w_winner = SRC_NMI;
        else if (w_irq_req)       w_winner = SRC_IRQ;
        else if (brk_inst)        w_winner = SRC_BRK;
    end

    always_comb begin
        case (w_winner)
            SRC_RESET:        w_vec = RST_VECTOR;
            SRC_NMI:          w_vec = NMI_VECTOR;
            SRC_IRQ, SRC_BRK: w_vec = IRQ_VECTOR;
            default:          w_vec = 16'h0000;
        endcase
    end

    // SERVICE never starts a new source, so nesting is impossible
    assign w_start   = enableFFs & poll & (r_state != SERVICE) & (w_winner != SRC_NONE);
    assign int_start = w_start;
    assign int_done  = enableFFs & vec_done & (r_state == SERVICE);

    // Edge detector is ungated; a fresh edge outranks the clear on the same clock
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_nmi_prev  <= 1'b1;
            r_nmi_latch <= 1'b0;
        end else begin
            r_nmi_prev <= w_nmi_sync;
            if (w_nmi_fall) begin
                r_nmi_latch <= 1'b1;
            end else if (w_start && (w_winner == SRC_NMI)) begin
                r_nmi_latch <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state   <= RST_PEND;
            r_int_src <= SRC_NONE;
            r_vector  <= 16'h0000;
            r_b_push  <= 1'b0;
        end else if (enableFFs) begin
            case (r_state)
                RST_PEND, IDLE: begin
                    if (w_start) begin
                        r_state   <= SERVICE;
                        r_int_src <= w_winner;
                        r_vector  <= w_vec;
                        r_b_push  <= (w_winner == SRC_BRK);
                    end
                end
                SERVICE: begin
                    if (vec_done) begin
                        r_state   <= IDLE;
                        r_int_src <= SRC_NONE;
                        r_vector  <= 16'h0000;
                        r_b_push  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= RST_PEND;
                end
            endcase
        end
    end

    assign int_src  = r_int_src;
    assign vector   = r_vector;
    assign b_push   = r_b_push;
    assign nmi_pend = r_nmi_latch;

endmodule

`default_nettype wire

// File: tb/tb_interrupt_arbiter.sv
// ---------------------------------------------------------------------------
// tb_interrupt_arbiter : directed scenarios plus random run against a model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_interrupt_arbiter;
    import interrupt_pkg::*;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        enableFFs = 1'b0;
    logic        irq_n = 1'b1;
    logic        nmi_n = 1'b1;
    logic        i_flag = 1'b1;
    logic        poll = 1'b0;
    logic        brk_inst = 1'b0;
    logic        vec_done = 1'b0;
    logic        int_start;
    logic        int_done;
    int_src_t    int_src;
    logic [15:0] vector;
    logic        b_push;
    logic        nmi_pend;

    int checks = 0;
    int errors = 0;

    // Model: reset-pending flag, source in service (NONE = idle), pending NMI,
    // and the recent history of each pin as sampled on rising clock edges.
    logic       m_rst;
    logic       m_nmi;
    int_src_t   m_src;
    logic [7:0] m_hn;
    logic [7:0] m_hi;

    always #5 clk = ~clk;

    interrupt_arbiter #(.SYNC_STAGES(SYNC)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .enableFFs (enableFFs),
        .irq_n     (irq_n),
        .nmi_n     (nmi_n),
        .i_flag    (i_flag),
        .poll      (poll),
        .brk_inst  (brk_inst),
        .vec_done  (vec_done),
        .int_start (int_start),
        .int_done  (int_done),
        .int_src   (int_src),
        .vector    (vector),
        .b_push    (b_push),
        .nmi_pend  (nmi_pend)
    );

    task automatic model_reset();
        m_rst = 1'b1;
        m_nmi = 1'b0;
        m_src = SRC_NONE;
        m_hn  = '1;
        m_hi  = '1;
    endtask

    // The core sees a pin value SYNC rising edges after it was sampled
    function automatic int_src_t m_win();
        logic irq_req;
        irq_req = ~m_hi[SYNC-1] & ~i_flag;
        if (m_rst)         return SRC_RESET;
        else if (m_nmi)    return SRC_NMI;
        else if (irq_req)  return SRC_IRQ;
        else if (brk_inst) return SRC_BRK;
        return SRC_NONE;
    endfunction

    function automatic logic m_start(input int_src_t w);
        return enableFFs & poll & (m_src == SRC_NONE) & (w != SRC_NONE);
    endfunction

    function automatic logic m_done();
        return enableFFs & vec_done & (m_src != SRC_NONE);
    endfunction

    function automatic logic [15:0] m_vec(input int_src_t s);
        case (s)
            SRC_RESET:        return 16'hFFFC;
            SRC_NMI:          return 16'hFFFA;
            SRC_IRQ, SRC_BRK: return 16'hFFFE;
            default:          return 16'h0000;
        endcase
    endfunction

    // Advance one clock; inputs are driven between ticks at the falling edge
    task automatic tick();
        int_src_t w;
        logic s, d, fall;
        w    = m_win();
        s    = m_start(w);
        d    = m_done();
        fall = m_hn[SYNC] & ~m_hn[SYNC-1];
        @(posedge clk);
        if (!nrst) begin
            model_reset();
        end else begin
            m_nmi = fall | (m_nmi & ~(s && (w == SRC_NMI)));
            if (d) m_src = SRC_NONE;
            else if (s) begin
                m_src = w;
                m_rst = 1'b0;
            end
            m_hn = {m_hn[6:0], nmi_n};
            m_hi = {m_hi[6:0], irq_n};
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        model_reset();
        enableFFs = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (int_src !== SRC_NONE) begin errors++; $display("FAIL rst_src got %0d exp %0d", int_src, SRC_NONE); end
        checks++; if (vector !== 16'h0000) begin errors++; $display("FAIL rst_vector got %h exp 0000", vector); end
        checks++; if ({b_push, nmi_pend, int_start} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {b_push, nmi_pend, int_start}); end
        @(negedge clk);
        nrst = 1'b1;
        poll = 1'b1;
        #1;
        checks++; if (int_start !== 1'b1) begin errors++; $display("FAIL rst_start got %b exp 1", int_start); end
        tick();
        poll = 1'b0;
        #1;
        checks++; if (int_src !== SRC_RESET) begin errors++; $display("FAIL rst_svc_src got %0d exp %0d", int_src, SRC_RESET); end
        checks++; if (vector !== 16'hFFFC || b_push !== 1'b0) begin errors++; $display("FAIL rst_svc_vec got %h/%b exp FFFC/0", vector, b_push); end
        vec_done = 1'b1;
        #1;
        checks++; if (int_done !== 1'b1) begin errors++; $display("FAIL rst_done got %b exp 1", int_done); end
        tick();
        vec_done = 1'b0;
        #1;
        checks++; if (vector !== 16'h0000 || int_src !== SRC_NONE) begin errors++; $display("FAIL rst_idle got %h/%0d exp 0000/0", vector, int_src); end
    endtask

    task automatic test_irq();
        i_flag = 1'b1;
        irq_n  = 1'b0;
        repeat (3) tick();
        poll = 1'b1;
        #1;
        checks++; if (int_start !== 1'b0) begin errors++; $display("FAIL irq_masked got %b exp 0", int_start); end
        tick();
        i_flag = 1'b0;
        #1;
        checks++; if (int_start !== 1'b1) begin errors++; $display("FAIL irq_start got %b exp 1", int_start); end
        tick();
        poll = 1'b0;
        #1;
        checks++; if (int_src !== SRC_IRQ || vector !== 16'hFFFE) begin errors++; $display("FAIL irq_svc got %0d/%h exp %0d/FFFE", int_src, vector, SRC_IRQ); end
        vec_done = 1'b1;
        tick();
        vec_done = 1'b0;
        irq_n    = 1'b1;
        i_flag   = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_nmi();
        nmi_n = 1'b0;
        tick();
        nmi_n = 1'b1;
        tick();
        #1;
        checks++; if (nmi_pend !== 1'b0) begin errors++; $display("FAIL nmi_early got %b exp 0", nmi_pend); end
        tick();
        #1;
        checks++; if (nmi_pend !== 1'b1) begin errors++; $display("FAIL nmi_latency got %b exp 1", nmi_pend); end
        repeat (2) tick();
        poll = 1'b1;
        #1;
        checks++; if (int_start !== 1'b1 || nmi_pend !== 1'b1) begin errors++; $display("FAIL nmi_start got %b/%b exp 1/1", int_start, nmi_pend); end
        tick();
        poll = 1'b0;
        #1;
        checks++; if (int_src !== SRC_NMI || vector !== 16'hFFFA || nmi_pend !== 1'b0) begin errors++; $display("FAIL nmi_svc got %0d/%h/%b exp %0d/FFFA/0", int_src, vector, nmi_pend, SRC_NMI); end
        vec_done = 1'b1;
        tick();
        vec_done = 1'b0;
        nmi_n = 1'b0;
        repeat (4) tick();
        poll = 1'b1;
        tick();
        poll = 1'b0;
        vec_done = 1'b1;
        tick();
        vec_done = 1'b0;
        repeat (6) tick();
        poll = 1'b1;
        #1;
        checks++; if (nmi_pend !== 1'b0 || int_start !== 1'b0) begin errors++; $display("FAIL nmi_hold got %b/%b exp 0/0", nmi_pend, int_start); end
        tick();
        poll  = 1'b0;
        nmi_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_priority();
        irq_n  = 1'b0;
        i_flag = 1'b0;
        nmi_n  = 1'b0;
        tick();
        nmi_n = 1'b1;
        repeat (3) tick();
        brk_inst = 1'b1;
        poll     = 1'b1;
        tick();
        poll = 1'b0;
        #1;
        checks++; if (int_src !== SRC_NMI) begin errors++; $display("FAIL prio_nmi got %0d exp %0d", int_src, SRC_NMI); end
        vec_done = 1'b1;
        tick();
        vec_done = 1'b0;
        poll     = 1'b1;
        tick();
        poll = 1'b0;
        #1;
        checks++; if (int_src !== SRC_IRQ || b_push !== 1'b0) begin errors++; $display("FAIL prio_irq got %0d/%b exp %0d/0", int_src, b_push, SRC_IRQ); end
        vec_done = 1'b1;
        tick();
        vec_done = 1'b0;
        irq_n    = 1'b1;
        repeat (3) tick();
        poll = 1'b1;
        tick();
        poll = 1'b0;
        #1;
        checks++; if (int_src !== SRC_BRK || b_push !== 1'b1 || vector !== 16'hFFFE) begin errors++; $display("FAIL prio_brk got %0d/%b/%h exp %0d/1/FFFE", int_src, b_push, vector, SRC_BRK); end
        vec_done = 1'b1;
        tick();
        vec_done = 1'b0;
        brk_inst = 1'b0;
        i_flag   = 1'b1;
    endtask

    task automatic test_back_to_back();
        irq_n  = 1'b0;
        i_flag = 1'b0;
        repeat (3) tick();
        poll = 1'b1;
        tick();
        poll  = 1'b0;
        nmi_n = 1'b0;
        tick();
        nmi_n = 1'b1;
        repeat (3) tick();
        #1;
        checks++; if (int_src !== SRC_IRQ || vector !== 16'hFFFE || nmi_pend !== 1'b1) begin errors++; $display("FAIL lock got %0d/%h/%b exp %0d/FFFE/1", int_src, vector, nmi_pend, SRC_IRQ); end
        irq_n    = 1'b1;
        i_flag   = 1'b1;
        vec_done = 1'b1;
        #1;
        checks++; if (int_done !== 1'b1) begin errors++; $display("FAIL lock_done got %b exp 1", int_done); end
        tick();
        vec_done = 1'b0;
        poll     = 1'b1;
        tick();
        poll = 1'b0;
        #1;
        checks++; if (int_src !== SRC_NMI || vector !== 16'hFFFA) begin errors++; $display("FAIL lock_nmi got %0d/%h exp %0d/FFFA", int_src, vector, SRC_NMI); end
        vec_done = 1'b1;
        tick();
        vec_done = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_enable_reset();
        irq_n  = 1'b0;
        i_flag = 1'b0;
        repeat (3) tick();
        enableFFs = 1'b0;
        poll      = 1'b1;
        #1;
        checks++; if (int_start !== 1'b0) begin errors++; $display("FAIL en_start got %b exp 0", int_start); end
        tick();
        #1;
        checks++; if (int_src !== SRC_NONE) begin errors++; $display("FAIL en_hold got %0d exp %0d", int_src, SRC_NONE); end
        enableFFs = 1'b1;
        tick();
        poll  = 1'b0;
        nmi_n = 1'b0;
        tick();
        nmi_n = 1'b1;
        repeat (3) tick();
        #1;
        checks++; if (int_src !== SRC_IRQ || nmi_pend !== 1'b1) begin errors++; $display("FAIL en_svc got %0d/%b exp %0d/1", int_src, nmi_pend, SRC_IRQ); end
        nrst = 1'b0;
        model_reset();
        #1;
        checks++; if (int_src !== SRC_NONE || nmi_pend !== 1'b0 || vector !== 16'h0000) begin errors++; $display("FAIL midrst got %0d/%b/%h exp 0/0/0000", int_src, nmi_pend, vector); end
        tick();
        nrst  = 1'b1;
        irq_n = 1'b1;
        poll  = 1'b1;
        tick();
        poll = 1'b0;
        #1;
        checks++; if (int_src !== SRC_RESET) begin errors++; $display("FAIL midrst_svc got %0d exp %0d", int_src, SRC_RESET); end
        vec_done = 1'b1;
        tick();
        vec_done = 1'b0;
        i_flag   = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_random();
        int_src_t w;
        for (int i = 0; i < 600; i++) begin
            enableFFs = ($urandom_range(0, 9) < 8);
            poll      = ($urandom_range(0, 9) < 3);
            brk_inst  = ($urandom_range(0, 9) < 2);
            i_flag    = $urandom_range(0, 1);
            vec_done  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) irq_n = ~irq_n;
            if ($urandom_range(0, 7) == 0) nmi_n = ~nmi_n;
            #1;
            w = m_win();
            checks++; if (int_start !== m_start(w)) begin errors++; $display("FAIL rnd_start cyc %0d got %b exp %b", i, int_start, m_start(w)); end
            checks++; if (int_done !== m_done()) begin errors++; $display("FAIL rnd_done cyc %0d got %b exp %b", i, int_done, m_done()); end
            checks++; if (int_src !== m_src) begin errors++; $display("FAIL rnd_src cyc %0d got %0d exp %0d", i, int_src, m_src); end
            checks++; if (vector !== m_vec(m_src)) begin errors++; $display("FAIL rnd_vector cyc %0d got %h exp %h", i, vector, m_vec(m_src)); end
            checks++; if (b_push !== (m_src == SRC_BRK)) begin errors++; $display("FAIL rnd_bpush cyc %0d got %b exp %b", i, b_push, (m_src == SRC_BRK)); end
            checks++; if (nmi_pend !== m_nmi) begin errors++; $display("FAIL rnd_nmipend cyc %0d got %b exp %b", i, nmi_pend, m_nmi); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_irq();
        test_nmi();
        test_priority();
        test_back_to_back();
        test_enable_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
